// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multicycle main controller: state encoding,
// opcodes, ALUOp values, mux-select encodings and the control bundle.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_EXEC_R   = 4'd2,
        ST_EXEC_I   = 4'd3,
        ST_MEM_ADDR = 4'd4,
        ST_MEM_RD   = 4'd5,
        ST_MEM_WR   = 4'd6,
        ST_WB_R     = 4'd7,
        ST_WB_I     = 4'd8,
        ST_WB_MEM   = 4'd9,
        ST_BRANCH   = 4'd10,
        ST_JUMP     = 4'd11
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    localparam logic [2:0] ALU_FUNCT = 3'b000;
    localparam logic [2:0] ALU_ADD   = 3'b001;
    localparam logic [2:0] ALU_SLTU  = 3'b010;
    localparam logic [2:0] ALU_LUI   = 3'b011;
    localparam logic [2:0] ALU_BEQ   = 3'b100;
    localparam logic [2:0] ALU_BNE   = 3'b110;
    localparam logic [2:0] ALU_OR    = 3'b111;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_BRADDR = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_TARGET = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       iord;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic [2:0] alu_op;
        logic       illegal;
    } ctrl_t;

    // DECODE dispatch target; ST_FETCH doubles as the "undefined opcode" marker.
    function automatic state_e dispatch(input logic [5:0] op);
        case (op)
            OP_RTYPE:                           return ST_EXEC_R;
            OP_LW, OP_SW:                       return ST_MEM_ADDR;
            OP_BEQ, OP_BNE:                     return ST_BRANCH;
            OP_J:                               return ST_JUMP;
            OP_ADDI, OP_SLTIU, OP_LUI, OP_ORI:  return ST_EXEC_I;
            default:                            return ST_FETCH;
        endcase
    endfunction

    function automatic logic [2:0] imm_alu_op(input logic [5:0] op);
        case (op)
            OP_SLTIU: return ALU_SLTU;
            OP_LUI:   return ALU_LUI;
            OP_ORI:   return ALU_OR;
            default:  return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational output decode for the multicycle controller: current state
// plus opcode, zero flag and memory handshake into the control bundle.
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
(
    input  state_e     state_i,
    input  logic [5:0] op_i,
    input  logic       zero_i,
    input  logic       mem_ready_i,
    output ctrl_t      ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            ST_FETCH: begin
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.alu_src_b = SRCB_FOUR;
                ctrl_o.alu_op    = ALU_ADD;
                ctrl_o.pc_src    = PCSRC_ALU;
                ctrl_o.ir_write  = mem_ready_i;
                ctrl_o.pc_write  = mem_ready_i;
            end
            ST_DECODE: begin
                ctrl_o.alu_src_b = SRCB_BRADDR;
                ctrl_o.alu_op    = ALU_ADD;
                ctrl_o.illegal   = (dispatch(op_i) == ST_FETCH);
            end
            ST_EXEC_R: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_op    = ALU_FUNCT;
            end
            ST_EXEC_I: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = imm_alu_op(op_i);
            end
            ST_MEM_ADDR: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = ALU_ADD;
            end
            ST_MEM_RD: begin
                ctrl_o.mem_read = 1'b1;
                ctrl_o.iord     = 1'b1;
            end
            ST_MEM_WR: begin
                ctrl_o.mem_write = 1'b1;
                ctrl_o.iord      = 1'b1;
            end
            ST_WB_R: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.reg_dst   = 1'b1;
            end
            ST_WB_I: begin
                ctrl_o.reg_write = 1'b1;
            end
            ST_WB_MEM: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
            end
            ST_BRANCH: begin
                // bne is taken on a non-zero compare, beq on zero
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.pc_src    = PCSRC_TARGET;
                ctrl_o.alu_op    = (op_i == OP_BNE) ? ALU_BNE : ALU_BEQ;
                ctrl_o.pc_write  = (op_i == OP_BNE) ? ~zero_i : zero_i;
            end
            ST_JUMP: begin
                ctrl_o.pc_write = 1'b1;
                ctrl_o.pc_src   = PCSRC_JUMP;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_main_ctrl.sv
// Multicycle main controller: state register, next-state logic and output
// strobes. Define MC_PERF_CNT_EN to add cycle/instruction counter outputs.
module mc_main_ctrl
    import mc_ctrl_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [5:0] op_i,
    input  logic       zero_i,
    input  logic       mem_ready_i,
    output logic       pc_write_o,
    output logic       ir_write_o,
    output logic       mem_read_o,
    output logic       mem_write_o,
    output logic       reg_write_o,
    output logic       iord_o,
    output logic       reg_dst_o,
    output logic       mem_to_reg_o,
    output logic       alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [1:0] pc_src_o,
    output logic [2:0] alu_op_o,
    output logic       illegal_o,
    output logic [3:0] state_o
`ifdef MC_PERF_CNT_EN
    ,
    output logic [31:0] cycle_cnt_o,
    output logic [31:0] instr_cnt_o
`endif
);

    state_e state_q, state_d;
    ctrl_t  ctrl;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state_q <= ST_FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH:    if (mem_ready_i) state_d = ST_DECODE;
            ST_DECODE:   state_d = dispatch(op_i);
            ST_EXEC_R:   state_d = ST_WB_R;
            ST_EXEC_I:   state_d = ST_WB_I;
            ST_MEM_ADDR: state_d = (op_i == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
            ST_MEM_RD:   if (mem_ready_i) state_d = ST_WB_MEM;
            ST_MEM_WR:   if (mem_ready_i) state_d = ST_FETCH;
            default:     state_d = ST_FETCH;
        endcase
    end

    mc_ctrl_decode u_decode (
        .state_i     (state_q),
        .op_i        (op_i),
        .zero_i      (zero_i),
        .mem_ready_i (mem_ready_i),
        .ctrl_o      (ctrl)
    );

    // FETCH is the reset state, so its PC/IR updates must be gated off in reset
    assign pc_write_o   = ctrl.pc_write & rst_i;
    assign ir_write_o   = ctrl.ir_write & rst_i;
    assign mem_read_o   = ctrl.mem_read;
    assign mem_write_o  = ctrl.mem_write;
    assign reg_write_o  = ctrl.reg_write;
    assign iord_o       = ctrl.iord;
    assign reg_dst_o    = ctrl.reg_dst;
    assign mem_to_reg_o = ctrl.mem_to_reg;
    assign alu_src_a_o  = ctrl.alu_src_a;
    assign alu_src_b_o  = ctrl.alu_src_b;
    assign pc_src_o     = ctrl.pc_src;
    assign alu_op_o     = ctrl.alu_op;
    assign illegal_o    = ctrl.illegal;
    assign state_o      = state_q;

`ifdef MC_PERF_CNT_EN
    logic [31:0] cycle_cnt_q, instr_cnt_q;
    logic        retire;

    // An instruction retires on entering FETCH from a final state; illegal
    // returns come from DECODE and are therefore excluded.
    always_comb begin
        retire = (state_d == ST_FETCH) &&
                 (state_q inside {ST_WB_R, ST_WB_I, ST_WB_MEM, ST_BRANCH, ST_JUMP, ST_MEM_WR});
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
        end else begin
            cycle_cnt_q <= cycle_cnt_q + 32'd1;
            if (retire) instr_cnt_q <= instr_cnt_q + 32'd1;
        end
    end

    assign cycle_cnt_o = cycle_cnt_q;
    assign instr_cnt_o = instr_cnt_q;
`endif

endmodule

// File: doc/mc_main_ctrl.md
MC_MAIN_CTRL -- requirements
Module: mc_main_ctrl

Interface
REQ-001 SHALL have port clk_i, input, 1, the single clock; all state updates occur on the rising edge.
REQ-002 SHALL have port rst_i, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port op_i, input, 6, opcode field of the instruction register.
REQ-004 SHALL have port zero_i, input, 1, ALU zero flag from the current EX cycle.
REQ-005 SHALL have port mem_ready_i, input, 1, memory handshake; the access completes in the cycle it is high.
REQ-006 SHALL have ports pc_write_o, ir_write_o, mem_read_o, mem_write_o, reg_write_o, output, 1 each, the write and access strobes.
REQ-007 SHALL have ports iord_o, reg_dst_o, mem_to_reg_o, alu_src_a_o, output, 1 each, the mux selects.
REQ-008 SHALL have ports alu_src_b_o and pc_src_o, output, 2 each, the mux selects.
REQ-009 SHALL have port alu_op_o, output, 3, ALUOp to the ALU control decoder.
REQ-010 SHALL have ports illegal_o (output, 1, one-cycle pulse on an undefined opcode) and state_o (output, 4, current state for debug).

Function
REQ-011 SHALL implement the states FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR, WB_R, WB_I, WB_MEM, BRANCH and JUMP.
REQ-012 FETCH SHALL assert mem_read_o with iord_o=0, and SHALL hold until mem_ready_i=1; that cycle SHALL assert ir_write_o and pc_write_o (PC+4: alu_src_a_o=0, alu_src_b_o=01, alu_op_o=001, pc_src_o=00), then go to DECODE.
REQ-013 DECODE SHALL compute the branch target (alu_src_b_o=11, alu_op_o=001) and dispatch on op_i as follows.
- 000000 goes to EXEC_R.
- 100011 and 101011 go to MEM_ADDR.
- 000100 and 000101 go to BRANCH.
- 000010 goes to JUMP.
- 001000, 001011, 001111 and 001101 go to EXEC_I.
- Any other opcode SHALL pulse illegal_o and return to FETCH with no write strobe.
REQ-014 EXEC_R SHALL drive alu_op_o=000, then go to WB_R; WB_R SHALL assert reg_write_o with reg_dst_o=1.
REQ-015 EXEC_I SHALL drive alu_src_b_o=10 and alu_op_o by opcode, then go to WB_I; WB_I SHALL assert reg_write_o with reg_dst_o=0.
- addi drives 001.
- sltiu drives 010.
- lui drives 011.
- ori drives 111.
REQ-016 MEM_ADDR SHALL drive alu_op_o=001 with alu_src_b_o=10, then go to MEM_RD (lw) or MEM_WR (sw).
REQ-017 MEM_RD and MEM_WR SHALL assert mem_read_o or mem_write_o respectively, with iord_o=1, until mem_ready_i=1.
- MEM_RD then goes to WB_MEM.
- MEM_WR then goes to FETCH.
REQ-018 WB_MEM SHALL assert reg_write_o with mem_to_reg_o=1.
REQ-019 BRANCH SHALL drive alu_op_o=100 (beq) or 110 (bne) and pc_src_o=01.
- pc_write_o SHALL be asserted only when taken: beq with zero_i=1, or bne with zero_i=0.
REQ-020 JUMP SHALL assert pc_write_o with pc_src_o=10.
REQ-021 Every writeback state, BRANCH and JUMP SHALL go to FETCH the next cycle.
REQ-022 Unstalled latencies SHALL be:
- 4 cycles for R-type, I-type ALU and sw.
- 5 cycles for lw.
- 3 cycles for branch and jump.
REQ-023 Outputs SHALL be decoded from the current state (and op_i/zero_i), and every output not named for a state SHALL be 0.
REQ-024 Any write strobe SHALL be asserted for exactly one cycle per instruction; mem strobes SHALL remain high throughout a stall.

Reset
REQ-025 While rst_i=0, the state SHALL be FETCH and all registered flags SHALL be 0, independent of clk_i.
REQ-026 With the state at FETCH, the decoded outputs SHALL be mem_read_o=1 and every write strobe 0; pc_write_o and ir_write_o SHALL be masked to 0 while rst_i=0.
REQ-027 A reset mid-instruction (including mid-stall) SHALL abandon the instruction with no partial register write.
REQ-028 After reset release, the block SHALL begin a fresh fetch on the first clk_i edge.

Configuration
REQ-029 With MC_PERF_CNT_EN defined, the block SHALL add two 32-bit wrapping counter outputs.
- cycle_cnt_o SHALL increment every cycle out of reset.
- instr_cnt_o SHALL increment on each transition into FETCH from a writeback, BRANCH, JUMP or MEM_WR state, excluding illegal returns.
- Both counters SHALL clear on reset.
REQ-030 Without MC_PERF_CNT_EN, the counter ports and registers SHALL be absent and the remaining behaviour SHALL be identical.

Structure
REQ-031 Package mc_ctrl_pkg SHALL hold the state encoding, the opcode constants, the ALUOp constants (000, 001, 010, 011, 100, 110, 111) and the select encodings.
REQ-032 Sub-module mc_ctrl_decode SHALL implement the combinational decode of state, op_i and zero_i into the outputs; mc_main_ctrl SHALL hold the state register and next-state logic.

Verification
REQ-033 The bench SHALL cover these directed scenarios:
- R-type: op_i=000000 with mem_ready_i tied to 1 -> FETCH, DECODE, EXEC_R, WB_R; reg_write_o high only in cycle 4 with reg_dst_o=1; alu_op_o=000 in cycle 3.
- lw with mem_ready_i low for 3 cycles in MEM_RD -> mem_read_o and iord_o held for 4 cycles; reg_write_o with mem_to_reg_o=1 one cycle later; total 8 cycles.
- beq with zero_i=1 -> pc_write_o=1 and pc_src_o=01 in BRANCH; bne with zero_i=1 -> pc_write_o=0; both return to FETCH.
- op_i=111111 -> illegal_o pulses one cycle in DECODE; next state FETCH; no strobes.
- rst_i dropped mid-FETCH-stall -> immediate return to FETCH with all write strobes 0; with MC_PERF_CNT_EN, both counters read 0.
- ori then lui back-to-back -> alu_op_o=111 and then 011 in EXEC_I; with MC_PERF_CNT_EN, instr_cnt_o=2 and cycle_cnt_o=8.
